stage_writeback_arb: RTL and testbench

- Parametrised, registered writeback stage: selects the pipeline result, aligns and extends load data, and arbitrates the single regfile write port against a long-latency (mul/div) return channel.
- Sits between the memory stage and the register file / forwarding network.
- Adds handshake-based stalling and a starvation limiter so that neither source can lock out the other indefinitely.

---
 rtl/stage_writeback_arb.sv | 126 ++++++++++++
 tb/tb_stage_writeback_arb.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/stage_writeback_arb.sv
// Registered writeback stage: picks the pipeline result, aligns/extends load data,
// and arbitrates the single regfile write port against a long-latency return channel.
module stage_writeback_arb #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned MAX_WAIT   = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [REG_ADDR_W-1:0]      mem_rd,
    input  logic [1:0]                 mem_result_src,
    input  logic [XLEN-1:0]            mem_alu_result,
    input  logic [XLEN-1:0]            mem_read_data,
    input  logic [2:0]                 mem_load_funct3,
    input  logic [$clog2(XLEN/8)-1:0]  mem_byte_offset,
    input  logic [XLEN-1:0]            mem_instr_addr_plus,
    input  logic                       mem_regfile_wr_enable,
    input  logic                       ll_valid,
    output logic                       ll_ready,
    input  logic [REG_ADDR_W-1:0]      ll_rd,
    input  logic [XLEN-1:0]            ll_result,
    output logic [REG_ADDR_W-1:0]      wb_rd,
    output logic [XLEN-1:0]            wb_write_data,
    output logic                       wb_regfile_wr_enable,
    output logic                       wb_src_ll
);

    localparam int unsigned CW   = ($clog2(MAX_WAIT + 1) > 1) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0] CMAX = CW'(MAX_WAIT);

    logic [CW-1:0]         starve_q, starve_d;
    logic                  starve_hit;
    logic                  ll_xfer, mem_xfer;
    logic [XLEN-1:0]       sh, load_val, mem_val;

    logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]       wb_data_q, wb_data_d;
    logic                  wb_en_q, wb_en_d;
    logic                  wb_ll_q, wb_ll_d;

    // With MAX_WAIT=0 the long-latency channel is always considered starved.
    if (MAX_WAIT == 0) begin : g_ll_priority
        assign starve_hit = 1'b1;
    end else begin : g_ll_limited
        assign starve_hit = (starve_q >= CMAX);
    end

    assign ll_ready  = ll_valid & (~mem_valid | starve_hit);
    assign mem_ready = ~(ll_valid & starve_hit);
    assign ll_xfer   = ll_valid & ll_ready;
    assign mem_xfer  = mem_valid & mem_ready;

    always_comb begin
        starve_d = starve_q;
        if (!ll_valid || ll_xfer) begin
            starve_d = '0;
        end else if (!starve_hit) begin
            starve_d = starve_q + CW'(1);
        end
    end

    always_comb begin
        sh       = mem_read_data >> {mem_byte_offset, 3'b000};
        load_val = mem_read_data;
        case (mem_load_funct3)
            3'b000: load_val = XLEN'($signed(sh[7:0]));
            3'b001: load_val = XLEN'($signed(sh[15:0]));
            3'b010: load_val = XLEN'($signed(sh[31:0]));
            3'b100: load_val = XLEN'(sh[7:0]);
            3'b101: load_val = XLEN'(sh[15:0]);
            3'b110: if (XLEN == 64) load_val = XLEN'(sh[31:0]);
            3'b011: if (XLEN == 64) load_val = sh;
            default: load_val = mem_read_data;
        endcase
    end

    always_comb begin
        case (mem_result_src)
            2'b01:   mem_val = load_val;
            2'b10:   mem_val = mem_instr_addr_plus;
            default: mem_val = mem_alu_result;
        endcase
    end

    always_comb begin
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        wb_ll_d   = wb_ll_q;
        wb_en_d   = 1'b0;
        if (ll_xfer) begin
            wb_rd_d   = ll_rd;
            wb_data_d = ll_result;
            wb_ll_d   = 1'b1;
            wb_en_d   = (ll_rd != '0);
        end else if (mem_xfer) begin
            wb_rd_d   = mem_rd;
            wb_data_d = mem_val;
            wb_ll_d   = 1'b0;
            wb_en_d   = mem_regfile_wr_enable & (mem_rd != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q  <= '0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            wb_en_q   <= 1'b0;
            wb_ll_q   <= 1'b0;
        end else begin
            starve_q  <= starve_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            wb_en_q   <= wb_en_d;
            wb_ll_q   <= wb_ll_d;
        end
    end

    assign wb_rd                = wb_rd_q;
    assign wb_write_data        = wb_data_q;
    assign wb_regfile_wr_enable = wb_en_q;
    assign wb_src_ll            = wb_ll_q;

endmodule

// File: tb/tb_stage_writeback_arb.sv
// Scoreboard bench for stage_writeback_arb: directed vectors push expected writes,
// a negedge monitor pops one per observed handshake and compares the wb_* outputs.
module tb_stage_writeback_arb;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        en;
        logic        src;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_valid = 1'b0, z_mem_valid = 1'b0;
    logic [4:0]  mem_rd = '0;
    logic [1:0]  mem_result_src = '0;
    logic [31:0] mem_alu_result = '0, mem_read_data = '0, mem_instr_addr_plus = '0;
    logic [2:0]  mem_load_funct3 = '0;
    logic [1:0]  mem_byte_offset = '0;
    logic        mem_regfile_wr_enable = 1'b0;
    logic        ll_valid = 1'b0, z_ll_valid = 1'b0;
    logic [4:0]  ll_rd = '0;
    logic [31:0] ll_result = '0;

    logic        mem_ready, ll_ready, wb_en, wb_src_ll;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        z_mem_ready, z_ll_ready, z_wb_en, z_wb_src_ll;
    logic [4:0]  z_wb_rd;
    logic [31:0] z_wb_data;

    int   n_chk = 0, n_pass = 0;
    exp_t q[$];
    logic pend = 1'b0;
    int   pend_ev = 0, rst_ev = 0;

    always #5 clk = ~clk;

    stage_writeback_arb #(.XLEN(32), .REG_ADDR_W(5), .MAX_WAIT(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd),
        .mem_result_src(mem_result_src), .mem_alu_result(mem_alu_result),
        .mem_read_data(mem_read_data), .mem_load_funct3(mem_load_funct3),
        .mem_byte_offset(mem_byte_offset), .mem_instr_addr_plus(mem_instr_addr_plus),
        .mem_regfile_wr_enable(mem_regfile_wr_enable),
        .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_result(ll_result),
        .wb_rd(wb_rd), .wb_write_data(wb_data),
        .wb_regfile_wr_enable(wb_en), .wb_src_ll(wb_src_ll)
    );

    stage_writeback_arb #(.XLEN(32), .REG_ADDR_W(5), .MAX_WAIT(0)) dut_z (
        .clk(clk), .rst_n(rst_n),
        .mem_valid(z_mem_valid), .mem_ready(z_mem_ready), .mem_rd(mem_rd),
        .mem_result_src(mem_result_src), .mem_alu_result(mem_alu_result),
        .mem_read_data(mem_read_data), .mem_load_funct3(mem_load_funct3),
        .mem_byte_offset(mem_byte_offset), .mem_instr_addr_plus(mem_instr_addr_plus),
        .mem_regfile_wr_enable(mem_regfile_wr_enable),
        .ll_valid(z_ll_valid), .ll_ready(z_ll_ready), .ll_rd(ll_rd), .ll_result(ll_result),
        .wb_rd(z_wb_rd), .wb_write_data(z_wb_data),
        .wb_regfile_wr_enable(z_wb_en), .wb_src_ll(z_wb_src_ll)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    always @(negedge rst_n) rst_ev++;

    // A handshake seen in one cycle must show up on wb_* in the next.
    always @(negedge clk) begin
        exp_t e;
        if (pend && pend_ev == rst_ev) begin
            if (q.size() == 0) begin
                chk("unexpected write", 64'(wb_rd), 64'h7fff);
            end else begin
                e = q.pop_front();
                chk("wb_rd", 64'(wb_rd), 64'(e.rd));
                chk("wb_write_data", 64'(wb_data), 64'(e.data));
                chk("wb_regfile_wr_enable", 64'(wb_en), 64'(e.en));
                chk("wb_src_ll", 64'(wb_src_ll), 64'(e.src));
            end
        end
        pend    = rst_n && ((mem_valid && mem_ready) || (ll_valid && ll_ready));
        pend_ev = rst_ev;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_mem(input logic [4:0] rd, input logic [1:0] src, input logic [31:0] alu,
                             input logic [31:0] rdata, input logic [2:0] f3, input logic [1:0] off,
                             input logic [31:0] pc, input logic wren);
        mem_valid = 1'b1; mem_rd = rd; mem_result_src = src; mem_alu_result = alu;
        mem_read_data = rdata; mem_load_funct3 = f3; mem_byte_offset = off;
        mem_instr_addr_plus = pc; mem_regfile_wr_enable = wren;
    endtask

    task automatic mem_case(input logic [4:0] rd, input logic [1:0] src, input logic [31:0] alu,
                            input logic [2:0] f3, input logic [1:0] off, input logic [31:0] pc,
                            input logic wren, input logic [31:0] exp_data);
        drive_mem(rd, src, alu, 32'h80FF7F01, f3, off, pc, wren);
        q.push_back('{rd: rd, data: exp_data, en: wren && (rd != 0), src: 1'b0});
        tick();
    endtask

    initial begin
        #3;
        chk("reset wb_rd", 64'(wb_rd), 0);
        chk("reset wb_write_data", 64'(wb_data), 0);
        chk("reset wb_regfile_wr_enable", 64'(wb_en), 0);
        chk("reset wb_src_ll", 64'(wb_src_ll), 0);
        #5 rst_n = 1'b1;
        tick();

        mem_case(5'd5,  2'b00, 32'h1234, 3'b000, 2'd0, 32'h0,   1'b1, 32'h1234);
        mem_case(5'd6,  2'b10, 32'h1234, 3'b000, 2'd0, 32'h104, 1'b1, 32'h104);
        mem_case(5'd7,  2'b01, 32'hAAAA, 3'b000, 2'd3, 32'h0,   1'b1, 32'hFFFFFF80);
        mem_case(5'd8,  2'b01, 32'hAAAA, 3'b100, 2'd2, 32'h0,   1'b1, 32'h000000FF);
        mem_case(5'd9,  2'b01, 32'hAAAA, 3'b100, 2'd1, 32'h0,   1'b1, 32'h0000007F);
        mem_case(5'd10, 2'b01, 32'hAAAA, 3'b001, 2'd2, 32'h0,   1'b1, 32'hFFFF80FF);
        mem_case(5'd11, 2'b01, 32'hAAAA, 3'b101, 2'd0, 32'h0,   1'b1, 32'h00007F01);
        mem_case(5'd12, 2'b01, 32'hAAAA, 3'b010, 2'd0, 32'h0,   1'b1, 32'h80FF7F01);
        mem_case(5'd13, 2'b01, 32'hAAAA, 3'b011, 2'd1, 32'h0,   1'b1, 32'h80FF7F01);
        mem_case(5'd14, 2'b01, 32'hAAAA, 3'b110, 2'd0, 32'h0,   1'b1, 32'h80FF7F01);
        mem_case(5'd15, 2'b11, 32'h5555, 3'b000, 2'd0, 32'h0,   1'b1, 32'h5555);
        mem_case(5'd0,  2'b00, 32'h77,   3'b000, 2'd0, 32'h0,   1'b1, 32'h77);
        mem_case(5'd3,  2'b00, 32'h99,   3'b000, 2'd0, 32'h0,   1'b0, 32'h99);
        mem_valid = 1'b0;
        tick();
        chk("idle wr_enable", 64'(wb_en), 0);
        chk("idle holds wb_rd", 64'(wb_rd), 3);
        chk("idle holds data", 64'(wb_data), 32'h99);

        // LL write to x0: strobe suppressed, data/src still update
        ll_valid = 1'b1; ll_rd = 5'd0; ll_result = 32'h55;
        q.push_back('{rd: 5'd0, data: 32'h55, en: 1'b0, src: 1'b1});
        #1 chk("ll alone ready", 64'(ll_ready), 1);
        tick();
        ll_valid = 1'b0;
        tick();

        // starvation limiter: LL refused cycles 0-2, wins cycle 3
        for (int c = 0; c < 5; c++) begin
            int m;
            m = (c < 3) ? c : 3;
            drive_mem(5'(16 + m), 2'b00, 32'h100 + 32'(m), 32'h0, 3'b000, 2'd0, 32'h0, 1'b1);
            ll_valid = (c < 4); ll_rd = 5'd9; ll_result = 32'hDEAD;
            if (c == 3) q.push_back('{rd: 5'd9, data: 32'hDEAD, en: 1'b1, src: 1'b1});
            else        q.push_back('{rd: 5'(16 + m), data: 32'h100 + 32'(m), en: 1'b1, src: 1'b0});
            #1;
            chk($sformatf("starve c%0d ll_ready", c), 64'(ll_ready), 64'(c == 3));
            chk($sformatf("starve c%0d mem_ready", c), 64'(mem_ready), 64'(c != 3));
            if (c == 4) chk("starve c4 wb_src_ll", 64'(wb_src_ll), 1);
            tick();
        end
        mem_valid = 1'b0;
        tick();

        // async reset mid-wait (starve_cnt=2), then a full 3-cycle wait again
        ll_valid = 1'b1; ll_rd = 5'd21; ll_result = 32'hBEEF;
        drive_mem(5'd20, 2'b00, 32'h200, 32'h0, 3'b000, 2'd0, 32'h0, 1'b1);
        q.push_back('{rd: 5'd20, data: 32'h200, en: 1'b1, src: 1'b0});
        tick();
        drive_mem(5'd22, 2'b00, 32'h201, 32'h0, 3'b000, 2'd0, 32'h0, 1'b1);
        q.push_back('{rd: 5'd22, data: 32'h201, en: 1'b1, src: 1'b0});
        tick();
        drive_mem(5'd23, 2'b00, 32'h202, 32'h0, 3'b000, 2'd0, 32'h0, 1'b1);
        #5 rst_n = 1'b0;
        #1;
        chk("mid reset wb_rd", 64'(wb_rd), 0);
        chk("mid reset wb_write_data", 64'(wb_data), 0);
        chk("mid reset wb_src_ll", 64'(wb_src_ll), 0);
        #4 rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            int m;
            m = (c < 3) ? c : 3;
            drive_mem(5'(23 + m), 2'b00, 32'h202 + 32'(m), 32'h0, 3'b000, 2'd0, 32'h0, 1'b1);
            ll_valid = (c < 4);
            if (c == 3) q.push_back('{rd: 5'd21, data: 32'hBEEF, en: 1'b1, src: 1'b1});
            else        q.push_back('{rd: 5'(23 + m), data: 32'h202 + 32'(m), en: 1'b1, src: 1'b0});
            #1;
            chk($sformatf("post-reset c%0d ll_ready", c), 64'(ll_ready), 64'(c == 3));
            chk($sformatf("post-reset c%0d mem_ready", c), 64'(mem_ready), 64'(c != 3));
            tick();
        end
        mem_valid = 1'b0;
        tick();

        // MAX_WAIT=0: LL wins every cycle while held
        z_mem_valid = 1'b1; z_ll_valid = 1'b1; ll_rd = 5'd12;
        for (int i = 0; i < 3; i++) begin
            ll_result = 32'h300 + 32'(i);
            #1;
            chk($sformatf("mw0 i%0d ll_ready", i), 64'(z_ll_ready), 1);
            chk($sformatf("mw0 i%0d mem_ready", i), 64'(z_mem_ready), 0);
            tick();
            chk($sformatf("mw0 i%0d wb_data", i), 64'(z_wb_data), 64'(32'h300 + 32'(i)));
            chk($sformatf("mw0 i%0d wb_src_ll", i), 64'(z_wb_src_ll), 1);
        end
        z_ll_valid = 1'b0;
        #1 chk("mw0 mem_ready after ll", 64'(z_mem_ready), 1);
        z_mem_valid = 1'b0;
        tick();
        tick();

        chk("scoreboard drained", 64'(q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
